dstage_2: RTL and testbench

DSTAGE_2 -- requirements
Module: dstage_2

---
 rtl/dstage_2_if.sv | 49 ++++
 rtl/dstage_2.sv | 187 ++++++++++++++++++
 tb/tb_dstage_2.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dstage_2_if.sv
// Bundle between dstage_2 and its upstream pipeline, the tag/data/PLRU arrays and the memory port.
// master = upstream/array side, slave = dstage_2.
interface dstage_2_if #(
    parameter int TAG_W    = 23,
    parameter int NUM_WAYS = 4
);
    typedef struct packed {
        logic [31:0]      addr;
        logic [TAG_W-1:0] tag;
        logic [3:0]       set_no;
        logic [4:0]       offset;
        logic [3:0]       rmask;
        logic [3:0]       wmask;
        logic [31:0]      wdata;
    } stage_reg_t;

    stage_reg_t                       stage_reg;
    logic [NUM_WAYS-1:0][TAG_W:0]     tag_out;
    logic [NUM_WAYS-1:0]              valid_out;
    logic [NUM_WAYS-1:0][255:0]       data_out;
    logic [2:0]                       lru_read;
    logic [2:0]                       lru_write;
    logic                             lru_web;
    logic [31:0]                      ufp_rdata;
    logic                             ufp_resp;
    logic [31:0]                      dfp_addr;
    logic                             dfp_read;
    logic                             dfp_write;
    logic [255:0]                     dfp_wdata;
    logic                             dfp_resp;
    logic                             read_halt;
    logic                             dirty_halt;
    logic                             write_halt;
    logic [1:0]                       write_way;
    logic [31:0]                      hit_count;
    logic [31:0]                      miss_count;

    modport master (
        output stage_reg, tag_out, valid_out, data_out, lru_read, dfp_resp,
        input  lru_write, lru_web, ufp_rdata, ufp_resp, dfp_addr, dfp_read, dfp_write,
               dfp_wdata, read_halt, dirty_halt, write_halt, write_way, hit_count, miss_count
    );

    modport slave (
        input  stage_reg, tag_out, valid_out, data_out, lru_read, dfp_resp,
        output lru_write, lru_web, ufp_rdata, ufp_resp, dfp_addr, dfp_read, dfp_write,
               dfp_wdata, read_halt, dirty_halt, write_halt, write_way, hit_count, miss_count
    );
endinterface

// File: rtl/dstage_2.sv
// Cache compare/miss stage: hit detection, PLRU update, dirty writeback and line allocate.
// Optional macro DSTAGE2_PERF_CNT_EN adds saturating hit/miss counters.
module dstage_2 #(
    parameter int TAG_W    = 23,
    parameter int NUM_WAYS = 4
) (
    input  logic       clk,
    input  logic       rst,
    dstage_2_if.slave  bus
);
    localparam logic [1:0] COMPARE   = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] ALLOCATE  = 2'd2;
    localparam logic [1:0] REFILL    = 2'd3;

    logic [1:0]          state_reg, state_next;
    logic [1:0]          victim_reg, victim_next;
    logic [NUM_WAYS-1:0] hit_vec;
    logic                hit_any;
    logic [1:0]          hit_way;
    logic [1:0]          victim;
    logic                victim_dirty;
    logic                active;
    logic                cmp_hit;
    logic                cmp_miss;
    logic [255:0]        hit_line;
    logic [7:0]          word_lsb;

    logic [2:0]          lru_write_c;
    logic                lru_web_c;
    logic [31:0]         ufp_rdata_c;
    logic                ufp_resp_c;
    logic [31:0]         dfp_addr_c;
    logic                dfp_read_c;
    logic                dfp_write_c;
    logic [255:0]        dfp_wdata_c;
    logic                read_halt_c;
    logic                dirty_halt_c;
    logic                write_halt_c;
    logic [1:0]          write_way_c;

    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_hit
            assign hit_vec[gi] = bus.valid_out[gi] &&
                                 (bus.tag_out[gi][TAG_W-1:0] == bus.stage_reg.tag);
        end
    endgenerate

    assign hit_any = |hit_vec;

    // Scan downward so the lowest matching way is the one left standing.
    always_comb begin
        hit_way = 2'd0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i]) hit_way = 2'(i);
        end
    end

    always_comb begin
        if (bus.lru_read[0]) victim = bus.lru_read[1] ? 2'd0 : 2'd1;
        else                 victim = bus.lru_read[2] ? 2'd2 : 2'd3;
    end

    assign victim_dirty = bus.valid_out[victim] && bus.tag_out[victim][TAG_W];
    assign active       = (|bus.stage_reg.rmask) || (|bus.stage_reg.wmask);
    assign cmp_hit      = (state_reg == COMPARE) && active && hit_any;
    assign cmp_miss     = (state_reg == COMPARE) && active && !hit_any;
    assign hit_line     = bus.data_out[hit_way];
    assign word_lsb     = {bus.stage_reg.offset[4:2], 5'b0};

    always_comb begin
        state_next  = state_reg;
        victim_next = victim_reg;
        case (state_reg)
            COMPARE: begin
                if (cmp_miss) begin
                    victim_next = victim;
                    state_next  = victim_dirty ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: if (bus.dfp_resp) state_next = ALLOCATE;
            ALLOCATE:  if (bus.dfp_resp) state_next = REFILL;
            default:   state_next = COMPARE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= COMPARE;
            victim_reg <= 2'd0;
        end else begin
            state_reg  <= state_next;
            victim_reg <= victim_next;
        end
    end

    // All outputs are forced quiet while rst is high, including mid-miss.
    always_comb begin
        lru_write_c  = 3'b000;
        lru_web_c    = 1'b1;
        ufp_rdata_c  = 32'd0;
        ufp_resp_c   = 1'b0;
        dfp_addr_c   = 32'd0;
        dfp_read_c   = 1'b0;
        dfp_write_c  = 1'b0;
        dfp_wdata_c  = 256'd0;
        read_halt_c  = 1'b0;
        dirty_halt_c = 1'b0;
        write_halt_c = 1'b0;
        write_way_c  = 2'd0;
        if (!rst) begin
            case (state_reg)
                COMPARE: begin
                    if (cmp_hit) begin
                        ufp_resp_c = 1'b1;
                        lru_web_c  = 1'b0;
                        if (|bus.stage_reg.rmask) ufp_rdata_c = hit_line[word_lsb +: 32];
                        if (|bus.stage_reg.wmask) begin
                            write_halt_c = 1'b1;
                            write_way_c  = hit_way;
                        end
                        case (hit_way)
                            2'd0:    lru_write_c = {bus.lru_read[2], 1'b0, 1'b0};
                            2'd1:    lru_write_c = {bus.lru_read[2], 1'b1, 1'b0};
                            2'd2:    lru_write_c = {1'b0, bus.lru_read[1], 1'b1};
                            default: lru_write_c = {1'b1, bus.lru_read[1], 1'b1};
                        endcase
                    end
                end
                WRITEBACK: begin
                    dfp_write_c  = 1'b1;
                    dirty_halt_c = 1'b1;
                    read_halt_c  = 1'b1;
                    dfp_addr_c   = 32'({bus.tag_out[victim_reg][TAG_W-1:0],
                                        bus.stage_reg.set_no, 5'b0});
                    dfp_wdata_c  = bus.data_out[victim_reg];
                end
                ALLOCATE: begin
                    dfp_read_c  = 1'b1;
                    read_halt_c = 1'b1;
                    dfp_addr_c  = 32'({bus.stage_reg.tag, bus.stage_reg.set_no, 5'b0});
                end
                default: read_halt_c = 1'b1;
            endcase
        end
    end

    assign bus.lru_write  = lru_write_c;
    assign bus.lru_web    = lru_web_c;
    assign bus.ufp_rdata  = ufp_rdata_c;
    assign bus.ufp_resp   = ufp_resp_c;
    assign bus.dfp_addr   = dfp_addr_c;
    assign bus.dfp_read   = dfp_read_c;
    assign bus.dfp_write  = dfp_write_c;
    assign bus.dfp_wdata  = dfp_wdata_c;
    assign bus.read_halt  = read_halt_c;
    assign bus.dirty_halt = dirty_halt_c;
    assign bus.write_halt = write_halt_c;
    assign bus.write_way  = write_way_c;

`ifdef DSTAGE2_PERF_CNT_EN
    logic [31:0] hit_count_reg, miss_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_reg  <= 32'd0;
            miss_count_reg <= 32'd0;
        end else begin
            if (cmp_hit && hit_count_reg != 32'hFFFF_FFFF)
                hit_count_reg <= hit_count_reg + 32'd1;
            if (cmp_miss && miss_count_reg != 32'hFFFF_FFFF)
                miss_count_reg <= miss_count_reg + 32'd1;
        end
    end

    assign bus.hit_count  = rst ? 32'd0 : hit_count_reg;
    assign bus.miss_count = rst ? 32'd0 : miss_count_reg;
`else
    assign bus.hit_count  = 32'd0;
    assign bus.miss_count = 32'd0;
`endif

    // Address/store-data fields and the byte offset within a word are consumed upstream.
    logic unused_bits;
    assign unused_bits = ^{bus.stage_reg.addr, bus.stage_reg.wdata, bus.stage_reg.offset[1:0]};

endmodule

// File: tb/tb_dstage_2.sv
// Directed bench for dstage_2: stimulus pushes expected ufp/dfp transactions into
// queues, a negedge monitor pops and compares whenever the DUT presents one.
module tb_dstage_2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dstage_2_if #(.TAG_W(23), .NUM_WAYS(4)) bus ();
    dstage_2 #(.TAG_W(23), .NUM_WAYS(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [31:0] rdata;
        bit          chk_rdata;
        bit          wh;
        logic [1:0]  way;
        logic [2:0]  lru_w;
    } ufp_exp_t;

    typedef struct {
        bit           is_write;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } dfp_exp_t;

    ufp_exp_t ufp_q[$];
    dfp_exp_t dfp_q[$];
    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
        return l;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [22:0] tag, input logic [3:0] set_no,
                           input logic [4:0] off, input logic [3:0] rm, input logic [3:0] wm);
        bus.stage_reg.addr   = {tag, set_no, off};
        bus.stage_reg.tag    = tag;
        bus.stage_reg.set_no = set_no;
        bus.stage_reg.offset = off;
        bus.stage_reg.rmask  = rm;
        bus.stage_reg.wmask  = wm;
        bus.stage_reg.wdata  = 32'h5A5A_0000;
    endtask

    task automatic clear_ways();
        for (int w = 0; w < 4; w++) begin
            bus.valid_out[w] = 1'b0;
            bus.tag_out[w]   = 24'h000FFF;
            bus.data_out[w]  = mk_line(32'h1000_0000 * (w + 1));
        end
    endtask

    task automatic push_ufp(input logic [31:0] rdata, input bit chk_rdata, input bit wh,
                            input logic [1:0] way, input logic [2:0] lru_w);
        ufp_exp_t e;
        e.rdata = rdata; e.chk_rdata = chk_rdata; e.wh = wh; e.way = way; e.lru_w = lru_w;
        ufp_q.push_back(e);
    endtask

    task automatic push_dfp(input bit is_write, input logic [31:0] addr, input logic [255:0] wdata);
        dfp_exp_t e;
        e.is_write = is_write; e.addr = addr; e.wdata = wdata;
        dfp_q.push_back(e);
    endtask

    // Monitor: ufp responses and the first cycle of each dfp strobe are transactions.
    initial begin
        bit prev_rd = 0, prev_wr = 0;
        ufp_exp_t ue;
        dfp_exp_t de;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_rd = 0; prev_wr = 0;
            end else begin
                if (bus.ufp_resp) begin
                    if (ufp_q.size() == 0) begin
                        check("ufp_unexpected", 1, 0);
                    end else begin
                        ue = ufp_q.pop_front();
                        if (ue.chk_rdata) check("ufp_rdata", bus.ufp_rdata, ue.rdata);
                        check("write_halt", bus.write_halt, ue.wh);
                        if (ue.wh) check("write_way", bus.write_way, ue.way);
                        check("lru_web", bus.lru_web, 0);
                        check("lru_write", bus.lru_write, ue.lru_w);
                    end
                end
                if ((bus.dfp_read && !prev_rd) || (bus.dfp_write && !prev_wr)) begin
                    check("dfp_exclusive", bus.dfp_read && bus.dfp_write, 0);
                    if (dfp_q.size() == 0) begin
                        check("dfp_unexpected", 1, 0);
                    end else begin
                        de = dfp_q.pop_front();
                        check("dfp_write", bus.dfp_write, de.is_write);
                        check("dfp_read", bus.dfp_read, !de.is_write);
                        check("dfp_addr", bus.dfp_addr, de.addr);
                        if (de.is_write) begin
                            check("dfp_wdata", bus.dfp_wdata, de.wdata);
                            check("dirty_halt", bus.dirty_halt, 1);
                        end
                    end
                end
                prev_rd = bus.dfp_read;
                prev_wr = bus.dfp_write;
            end
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.dfp_resp = 1'b0;
        bus.lru_read = 3'b000;
        clear_ways();
        bus.valid_out[0] = 1'b1;
        bus.tag_out[0]   = 24'h000055;
        set_req(23'h55, 4'h1, 5'h00, 4'hF, 4'h0);

        // Reset with a would-be hit presented: everything must stay quiet.
        rst = 1'b1;
        repeat (2) step();
        @(negedge clk);
        check("rst_ufp_resp", bus.ufp_resp, 0);
        check("rst_lru_web", bus.lru_web, 1);
        check("rst_ufp_rdata", bus.ufp_rdata, 0);
        check("rst_dfp_strobes", {bus.dfp_read, bus.dfp_write}, 0);
        check("rst_halts", {bus.read_halt, bus.dirty_halt, bus.write_halt}, 0);
        check("rst_hit_count", bus.hit_count, 0);
        step();
        rst = 1'b0;
        set_req(23'h55, 4'h1, 5'h00, 4'h0, 4'h0);
        @(negedge clk);
        check("idle_ufp_resp", bus.ufp_resp, 0);
        check("idle_lru_web", bus.lru_web, 1);

        // Load hit way2, offset 0x08 -> word 2.
        step();
        clear_ways();
        bus.valid_out[2] = 1'b1; bus.tag_out[2] = 24'h000055;
        bus.lru_read = 3'b000;
        push_ufp(32'h3000_0002, 1, 0, 2'd0, 3'b001);
        set_req(23'h55, 4'h1, 5'h08, 4'hF, 4'h0);
        step();
        set_req(23'h55, 4'h1, 5'h08, 4'h0, 4'h0);

        // Store hit way1.
        step();
        clear_ways();
        bus.valid_out[1] = 1'b1; bus.tag_out[1] = 24'h800066;
        bus.lru_read = 3'b100;
        push_ufp(32'h0, 0, 1, 2'd1, 3'b110);
        set_req(23'h66, 4'h2, 5'h00, 4'h0, 4'b0011);
        step();
        set_req(23'h66, 4'h2, 5'h00, 4'h0, 4'h0);

        // Two ways match: lowest index (way1) wins.
        step();
        clear_ways();
        bus.valid_out[1] = 1'b1; bus.tag_out[1] = 24'h000077;
        bus.valid_out[3] = 1'b1; bus.tag_out[3] = 24'h000077;
        bus.lru_read = 3'b010;
        push_ufp(32'h2000_0001, 1, 0, 2'd0, 3'b010);
        set_req(23'h77, 4'h3, 5'h04, 4'hF, 4'h0);
        step();
        // Only way3 matches, last word of the line.
        bus.valid_out[1] = 1'b0;
        push_ufp(32'h4000_0007, 1, 0, 2'd0, 3'b111);
        set_req(23'h77, 4'h3, 5'h1C, 4'h1, 4'h0);
        step();
        set_req(23'h77, 4'h3, 5'h1C, 4'h0, 4'h0);

        // Clean miss: victim way0 invalid -> ALLOCATE, resp after 10 cycles, REFILL, hit.
        step();
        clear_ways();
        bus.lru_read = 3'b011;
        push_dfp(0, 32'h0015_78A0, 256'd0);
        set_req(23'hABC, 4'h5, 5'h10, 4'hF, 4'h0);
        step();
        repeat (10) step();
        bus.dfp_resp = 1'b1;
        step();
        bus.dfp_resp = 1'b0;
        bus.valid_out[0] = 1'b1; bus.tag_out[0] = 24'h000ABC;
        bus.data_out[0] = mk_line(32'hCAFE_0000);
        push_ufp(32'hCAFE_0004, 1, 0, 2'd0, 3'b000);
        @(negedge clk);
        check("refill_read_halt", bus.read_halt, 1);
        check("refill_no_strobe", {bus.dfp_read, bus.dfp_write}, 0);
        check("refill_no_resp", bus.ufp_resp, 0);
        step();
        step();
        set_req(23'hABC, 4'h5, 5'h10, 4'h0, 4'h0);

        // Dirty miss: victim way3 dirty tag 0x1234 -> WRITEBACK then ALLOCATE.
        step();
        clear_ways();
        bus.valid_out[3] = 1'b1; bus.tag_out[3] = {1'b1, 23'h1234};
        bus.lru_read = 3'b000;
        push_dfp(1, 32'h0024_6840, mk_line(32'h4000_0000));
        push_dfp(0, 32'h000E_EE40, 256'd0);
        set_req(23'h777, 4'h2, 5'h00, 4'hF, 4'h0);
        step();
        repeat (3) step();
        bus.dfp_resp = 1'b1;
        step();
        bus.dfp_resp = 1'b0;
        repeat (4) step();
        bus.dfp_resp = 1'b1;
        step();
        bus.dfp_resp = 1'b0;
        bus.tag_out[3] = 24'h000777;
        bus.data_out[3] = mk_line(32'hBEEF_0000);
        push_ufp(32'hBEEF_0000, 1, 0, 2'd0, 3'b101);
        step();
        step();
        set_req(23'h777, 4'h2, 5'h00, 4'h0, 4'h0);
        step();
`ifdef DSTAGE2_PERF_CNT_EN
        @(negedge clk);
        check("hit_count", bus.hit_count, 6);
        check("miss_count", bus.miss_count, 2);
`endif

        // Clean-but-valid victim goes straight to ALLOCATE; reset lands mid-read.
        clear_ways();
        bus.valid_out[0] = 1'b1; bus.tag_out[0] = 24'h000011;
        bus.lru_read = 3'b011;
        push_dfp(0, 32'h0000_4460, 256'd0);
        set_req(23'h22, 4'h3, 5'h00, 4'h1, 4'h0);
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rst_alloc_dfp_read", bus.dfp_read, 0);
        check("rst_alloc_ufp_resp", bus.ufp_resp, 0);
        step();
        rst = 1'b0;
        set_req(23'h22, 4'h3, 5'h00, 4'h0, 4'h0);
        @(negedge clk);
        check("post_rst_dfp_read", bus.dfp_read, 0);
        check("post_rst_read_halt", bus.read_halt, 0);
        check("post_rst_hit_count", bus.hit_count, 0);
        check("post_rst_miss_count", bus.miss_count, 0);
        // Back in COMPARE: a hit responds in the same cycle.
        step();
        push_ufp(32'h1000_0000, 1, 0, 2'd0, 3'b000);
        set_req(23'h11, 4'h3, 5'h00, 4'hF, 4'h0);
        step();
        set_req(23'h11, 4'h3, 5'h00, 4'h0, 4'h0);
        repeat (3) step();

        check("ufp_q_drained", ufp_q.size(), 0);
        check("dfp_q_drained", dfp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
